msx_mouse_reader: RTL and testbench



---
 rtl/msx_mouse_pkg.sv | 28 ++
 rtl/msx_sync2.sv | 26 ++
 rtl/msx_mouse_reader.sv | 165 ++++++++++++++++
 tb/tb_msx_mouse_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX joystick-port mouse reader.
package msx_mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PHASE,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_PHASES = 4;
    localparam int unsigned POS_W      = 9;

    // Position minus sign-extended delta in 11-bit signed arithmetic, clamped to [0, max_v].
    function automatic logic [POS_W-1:0] clamp_step(input logic [POS_W-1:0] pos,
                                                    input logic [7:0]       delta,
                                                    input logic [POS_W-1:0] max_v);
        logic signed [10:0] r;
        r = $signed({2'b00, pos}) - $signed({{3{delta[7]}}, delta});
        if (r < 0) begin
            clamp_step = '0;
        end else if (r > $signed({2'b00, max_v})) begin
            clamp_step = max_v;
        end else begin
            clamp_step = r[POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/msx_sync2.sv
// Generic N-bit two-flop synchronizer for asynchronous port pins.
module msx_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/msx_mouse_reader.sv
// Host-side MSX mouse reader: runs the four-nibble strobe handshake,
// assembles X/Y deltas and keeps a clamped absolute pointer position.
module msx_mouse_reader
    import msx_mouse_pkg::*;
#(
    parameter int unsigned SETTLE = 2148,
    parameter int unsigned X_MAX  = 255,
    parameter int unsigned Y_MAX  = 211
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       data_in,
    input  logic [1:0]       btn_n,
    output logic             strobe,
    output logic             busy,
    output logic             valid,
    output logic [7:0]       dx,
    output logic [7:0]       dy,
    output logic [1:0]       buttons,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos
);

    localparam int unsigned      CNT_W      = (SETTLE > 2) ? $clog2(SETTLE) : 2;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [1:0]       PHASE_LAST = 2'(NUM_PHASES - 1);
    localparam logic [POS_W-1:0] X_MAX_P    = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MAX_P    = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_RST      = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0] Y_RST      = POS_W'(Y_MAX / 2);

    logic [5:0] sync_out;
    logic [3:0] data_sync;
    logic [1:0] btn_sync;

    msx_sync2 #(.WIDTH(6)) u_sync (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .d       ({btn_n, data_in}),
        .q       (sync_out)
    );

    assign data_sync = sync_out[3:0];
    assign btn_sync  = sync_out[5:4];

    state_t           state_q,   state_d;
    logic [1:0]       phase_q,   phase_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             strobe_q,  strobe_d;
    logic             busy_q,    busy_d;
    logic             valid_q,   valid_d;
    logic [7:0]       dx_q,      dx_d;
    logic [7:0]       dy_q,      dy_d;
    logic [1:0]       buttons_q, buttons_d;
    logic [POS_W-1:0] x_q,       x_d;
    logic [POS_W-1:0] y_q,       y_d;
    // Only the first three nibbles are stored; the last is used straight from the synchronizer.
    logic [3:0]       nib_q [NUM_PHASES-1];
    logic [3:0]       nib_d [NUM_PHASES-1];

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        strobe_d  = strobe_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        dx_d      = dx_q;
        dy_d      = dy_q;
        buttons_d = buttons_q;
        x_d       = x_q;
        y_d       = y_q;
        nib_d     = nib_q;

        case (state_q)
            ST_IDLE: begin
                strobe_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    state_d  = ST_PHASE;
                    phase_d  = '0;
                    strobe_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_RELOAD;
                end
            end
            ST_PHASE: begin
                if (cnt_q == '0) begin
                    if (phase_q == PHASE_LAST) begin
                        state_d   = ST_DONE;
                        phase_d   = '0;
                        strobe_d  = 1'b0;
                        busy_d    = 1'b0;
                        valid_d   = 1'b1;
                        dx_d      = {nib_q[0], nib_q[1]};
                        dy_d      = {nib_q[2], data_sync};
                        buttons_d = ~btn_sync;
                        x_d       = clamp_step(x_q, dx_d, X_MAX_P);
                        y_d       = clamp_step(y_q, dy_d, Y_MAX_P);
                    end else begin
                        for (int unsigned i = 0; i < NUM_PHASES - 1; i++) begin
                            if (phase_q == 2'(i)) begin
                                nib_d[i] = data_sync;
                            end
                        end
                        phase_d  = phase_q + 2'd1;
                        strobe_d = ~strobe_q;
                        cnt_d    = CNT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            buttons_q <= '0;
            x_q       <= X_RST;
            y_q       <= Y_RST;
            for (int unsigned i = 0; i < NUM_PHASES - 1; i++) begin
                nib_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            buttons_q <= buttons_d;
            x_q       <= x_d;
            y_q       <= y_d;
            nib_q     <= nib_d;
        end
    end

    assign strobe  = strobe_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign dx      = dx_q;
    assign dy      = dy_q;
    assign buttons = buttons_q;
    assign x_pos   = x_q;
    assign y_pos   = y_q;

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed self-checking bench for msx_mouse_reader with SETTLE=4.
module tb_msx_mouse_reader;

    localparam int S = 4;

    logic       clk_sys;
    logic       reset_n;
    logic       start;
    logic [3:0] data_in;
    logic [1:0] btn_n;
    logic       strobe;
    logic       busy;
    logic       valid;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] buttons;
    logic [8:0] x_pos;
    logic [8:0] y_pos;

    int n_cmp;
    int n_bad;

    // observations recorded by the transaction driver
    int         valid_cnt;
    int         valid_j;
    int         strobe_errs;
    int         busy_errs;
    logic [7:0] got_dx;
    logic [7:0] got_dy;
    logic [1:0] got_btn;
    logic [8:0] got_x;
    logic [8:0] got_y;
    logic       ab_strobe;
    logic       ab_busy;
    logic [8:0] ab_x;
    logic [8:0] ab_y;

    msx_mouse_reader #(
        .SETTLE (S),
        .X_MAX  (255),
        .Y_MAX  (211)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (start),
        .data_in (data_in),
        .btn_n   (btn_n),
        .strobe  (strobe),
        .busy    (busy),
        .valid   (valid),
        .dx      (dx),
        .dy      (dy),
        .buttons (buttons),
        .x_pos   (x_pos),
        .y_pos   (y_pos)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        data_in = 4'h0;
        btn_n   = 2'b11;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    // Must be called at a negedge. j counts posedges after the start-sampling edge;
    // inputs set at iteration j are sampled by edge j+1.
    task automatic run_txn(input logic [15:0] nibs, input int late_j,
                           input int extra_a, input int extra_b, input int reset_j);
        logic [15:0] sh;
        int          k;
        start       = 1'b1;
        valid_cnt   = 0;
        valid_j     = -1;
        strobe_errs = 0;
        busy_errs   = 0;
        @(posedge clk_sys);
        for (int j = 0; j <= 4 * S + 1; j++) begin
            @(negedge clk_sys);
            start = (j == extra_a) || (j == extra_b);
            if (j < 4 * S) begin
                k  = j / S;
                if (k == 1 && j < late_j) k = 0;
                sh = nibs >> (4 * (3 - k));
                data_in = sh[3:0];
            end
            if (j == reset_j) begin
                reset_n = 1'b0;
                #1;
                ab_strobe = strobe;
                ab_busy   = busy;
                ab_x      = x_pos;
                ab_y      = y_pos;
            end
            if (reset_j >= 0 && j == reset_j + 2) reset_n = 1'b1;
            if (!(reset_j >= 0 && j >= reset_j)) begin
                if (strobe !== ((j < 4 * S) ? (((j / S) % 2) == 0) : 1'b0)) strobe_errs++;
                if (busy !== (j < 4 * S)) busy_errs++;
            end
            if (valid === 1'b1) begin
                valid_cnt++;
                valid_j = j;
                got_dx  = dx;
                got_dy  = dy;
                got_btn = buttons;
                got_x   = x_pos;
                got_y   = y_pos;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%0b want=0", strobe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", valid); end
        n_cmp++; if (dx !== 8'h00 || dy !== 8'h00) begin n_bad++; $display("FAIL reset_delta got=%h/%h want=00/00", dx, dy); end
        n_cmp++; if (buttons !== 2'b00) begin n_bad++; $display("FAIL reset_buttons got=%b want=00", buttons); end
        n_cmp++; if (x_pos !== 9'd127) begin n_bad++; $display("FAIL reset_x got=%0d want=127", x_pos); end
        n_cmp++; if (y_pos !== 9'd105) begin n_bad++; $display("FAIL reset_y got=%0d want=105", y_pos); end
    endtask

    task automatic test_basic();
        do_reset();
        run_txn(16'h12FE, S, -1, -1, -1);
        n_cmp++; if (strobe_errs !== 0) begin n_bad++; $display("FAIL basic_strobe_pattern errors=%0d want=0", strobe_errs); end
        n_cmp++; if (busy_errs !== 0) begin n_bad++; $display("FAIL basic_busy errors=%0d want=0", busy_errs); end
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL basic_valid_count got=%0d want=1", valid_cnt); end
        n_cmp++; if (valid_j + 1 !== 4 * S + 1) begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", valid_j + 1, 4 * S + 1); end
        n_cmp++; if (got_dx !== 8'h12) begin n_bad++; $display("FAIL basic_dx got=%h want=12", got_dx); end
        n_cmp++; if (got_dy !== 8'hFE) begin n_bad++; $display("FAIL basic_dy got=%h want=fe", got_dy); end
        n_cmp++; if (got_x !== 9'd109) begin n_bad++; $display("FAIL basic_x got=%0d want=109", got_x); end
        n_cmp++; if (got_y !== 9'd107) begin n_bad++; $display("FAIL basic_y got=%0d want=107", got_y); end
        n_cmp++; if (got_btn !== 2'b00) begin n_bad++; $display("FAIL basic_buttons got=%b want=00", got_btn); end
    endtask

    task automatic test_clamp();
        do_reset();
        run_txn(16'h7AA1, S, -1, -1, -1);
        n_cmp++; if (got_x !== 9'd5) begin n_bad++; $display("FAIL clamp_setup_x got=%0d want=5", got_x); end
        n_cmp++; if (got_y !== 9'd200) begin n_bad++; $display("FAIL clamp_setup_y got=%0d want=200", got_y); end
        run_txn(16'h4080, S, -1, -1, -1);
        n_cmp++; if (got_x !== 9'd0) begin n_bad++; $display("FAIL clamp_low_x got=%0d want=0", got_x); end
        n_cmp++; if (got_y !== 9'd211) begin n_bad++; $display("FAIL clamp_high_y got=%0d want=211", got_y); end
        n_cmp++; if (x_pos !== 9'd0 || y_pos !== 9'd211) begin n_bad++; $display("FAIL clamp_hold got=%0d/%0d want=0/211", x_pos, y_pos); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_txn(16'h0101, S, 5, 4 * S, -1);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL b2b_first_valid_count got=%0d want=1", valid_cnt); end
        n_cmp++; if (strobe_errs !== 0 || busy_errs !== 0) begin n_bad++; $display("FAIL b2b_first_pattern errors=%0d/%0d want=0/0", strobe_errs, busy_errs); end
        n_cmp++; if (got_x !== 9'd126 || got_y !== 9'd104) begin n_bad++; $display("FAIL b2b_first_pos got=%0d/%0d want=126/104", got_x, got_y); end
        run_txn(16'hFFFF, S, -1, -1, -1);
        n_cmp++; if (valid_cnt !== 1 || valid_j !== 4 * S) begin n_bad++; $display("FAIL b2b_second_valid got=%0d@%0d want=1@%0d", valid_cnt, valid_j, 4 * S); end
        n_cmp++; if (strobe_errs !== 0 || busy_errs !== 0) begin n_bad++; $display("FAIL b2b_second_pattern errors=%0d/%0d want=0/0", strobe_errs, busy_errs); end
        n_cmp++; if (got_dx !== 8'hFF || got_x !== 9'd127 || got_y !== 9'd105) begin n_bad++; $display("FAIL b2b_second_result got=%h %0d/%0d want=ff 127/105", got_dx, got_x, got_y); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        run_txn(16'h12FE, S, -1, -1, -1);
        run_txn(16'h3333, S, -1, -1, 2 * S + 1);
        n_cmp++; if (ab_strobe !== 1'b0) begin n_bad++; $display("FAIL abort_strobe got=%0b want=0", ab_strobe); end
        n_cmp++; if (ab_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%0b want=0", ab_busy); end
        n_cmp++; if (ab_x !== 9'd127 || ab_y !== 9'd105) begin n_bad++; $display("FAIL abort_pos got=%0d/%0d want=127/105", ab_x, ab_y); end
        n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL abort_no_valid got=%0d want=0", valid_cnt); end
        n_cmp++; if (strobe !== 1'b0 || busy !== 1'b0 || x_pos !== 9'd127) begin n_bad++; $display("FAIL abort_idle got=%0b/%0b/%0d want=0/0/127", strobe, busy, x_pos); end
    endtask

    task automatic test_buttons_sync();
        do_reset();
        btn_n = 2'b01;
        run_txn(16'h3579, 2 * S - 2, -1, -1, -1);
        n_cmp++; if (got_btn !== 2'b10) begin n_bad++; $display("FAIL btn_state got=%b want=10", got_btn); end
        n_cmp++; if (got_dx !== 8'h33) begin n_bad++; $display("FAIL sync_late_dx got=%h want=33", got_dx); end
        n_cmp++; if (got_dy !== 8'h79) begin n_bad++; $display("FAIL sync_late_dy got=%h want=79", got_dy); end
        n_cmp++; if (got_x !== 9'd76 || got_y !== 9'd0) begin n_bad++; $display("FAIL sync_late_pos got=%0d/%0d want=76/0", got_x, got_y); end
        btn_n = 2'b10;
        run_txn(16'h3579, 2 * S - 3, -1, -1, -1);
        n_cmp++; if (got_dx !== 8'h35) begin n_bad++; $display("FAIL sync_ontime_dx got=%h want=35", got_dx); end
        n_cmp++; if (got_btn !== 2'b01) begin n_bad++; $display("FAIL btn_state2 got=%b want=01", got_btn); end
        n_cmp++; if (got_x !== 9'd23 || got_y !== 9'd0) begin n_bad++; $display("FAIL sync_ontime_pos got=%0d/%0d want=23/0", got_x, got_y); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        data_in = 4'h0;
        btn_n   = 2'b11;
        test_reset();
        test_basic();
        test_clamp();
        test_back_to_back();
        test_reset_abort();
        test_buttons_sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
